stack_alu_ext: RTL

STACK_ALU_EXT -- requirements
Module: stack_alu_ext

---
 rtl/stack_alu_ext.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stack_alu_ext.sv
// stack_alu_ext: N-bit stack calculator with handshake command interface.
// Optional macro STACK_ALU_MUL_EN enables a shift-add multiplier (MUL_BUSY state);
// without it, opcode MUL is reported as illegal.
module stack_alu_ext #(
  parameter int unsigned N          = 8,
  parameter int unsigned STACK_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [3:0]                        opcode,
  input  logic [N-1:0]                      input_data,
  output logic                              out_valid,
  output logic [N-1:0]                      output_data,
  output logic                              overflow,
  output logic                              error,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(STACK_SIZE+1)-1:0]   level
);

  localparam int unsigned LW = $clog2(STACK_SIZE + 1);
  localparam int unsigned AW = $clog2(STACK_SIZE);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_DUP  = 4'h1;
  localparam logic [3:0] OP_SWAP = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_PUSH = 4'h6;
  localparam logic [3:0] OP_POP  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;

`ifdef STACK_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MUL_BUSY = 2'd2} state_t;
  localparam int unsigned CW = $clog2(N + 1);
  logic [2*N-1:0] mul_a, mul_acc, mul_acc_nxt;
  logic [N-1:0]   mul_b;
  logic [CW-1:0]  mul_cnt;
  logic           mul_last;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t         state;
  logic [N-1:0]   mem [STACK_SIZE];

  logic [N-1:0]   top_v, nxt_v, res_c, top_nxt, wa_data, wb_data;
  logic [N:0]     sum_c;
  logic [LW-1:0]  level_nxt;
  logic [AW-1:0]  wa_addr, wb_addr;
  logic           wa_en, wb_en, wa_we, wb_we;
  logic           err_c, ovf_c, mul_start_c, accept, has1, has2, at_full;

  assign accept  = in_valid && in_ready;
  assign top_v   = mem[AW'(level - LW'(1))];
  assign nxt_v   = mem[AW'(level - LW'(2))];
  assign has1    = (level != LW'(0));
  assign has2    = (level >= LW'(2));
  assign at_full = (level == LW'(STACK_SIZE));
  assign sum_c   = {1'b0, nxt_v} + {1'b0, top_v};
  assign wb_addr = AW'(level - LW'(2));

`ifdef STACK_ALU_MUL_EN
  // One shift-add step of the multiplier
  assign mul_acc_nxt = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
  assign mul_last    = (mul_cnt == CW'(N - 1));
`endif

  // Decode the command against the current stack: result, error, stack writes
  always_comb begin
    err_c       = 1'b0;
    ovf_c       = 1'b0;
    mul_start_c = 1'b0;
    res_c       = '0;
    level_nxt   = level;
    top_nxt     = output_data;
    wa_en       = 1'b0;
    wb_en       = 1'b0;
    wa_addr     = AW'(level);
    wa_data     = input_data;
    wb_data     = top_v;
    case (opcode)
      OP_ADD: begin res_c = sum_c[N-1:0]; ovf_c = sum_c[N]; end
      OP_SUB: begin res_c = nxt_v - top_v; ovf_c = (top_v > nxt_v); end
      OP_AND: res_c = nxt_v & top_v;
      OP_OR:  res_c = nxt_v | top_v;
      OP_XOR: res_c = nxt_v ^ top_v;
      default: res_c = '0;
    endcase
    case (opcode)
      OP_NOP: ;
      OP_DUP: begin
        if (!has1 || at_full) err_c = 1'b1;
        else begin
          wa_en     = 1'b1;
          wa_data   = top_v;
          level_nxt = level + LW'(1);
          top_nxt   = top_v;
        end
      end
      OP_SWAP: begin
        if (!has2) err_c = 1'b1;
        else begin
          wa_en   = 1'b1;
          wa_addr = AW'(level - LW'(1));
          wa_data = nxt_v;
          wb_en   = 1'b1;
          wb_data = top_v;
          top_nxt = nxt_v;
        end
      end
      OP_CLR: begin
        level_nxt = '0;
        top_nxt   = '0;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        if (!has2) begin
          err_c = 1'b1;
          ovf_c = 1'b0;
        end else begin
          wb_en     = 1'b1;
          wb_data   = res_c;
          level_nxt = level - LW'(1);
          top_nxt   = res_c;
        end
      end
`ifdef STACK_ALU_MUL_EN
      OP_MUL: begin
        if (!has2) err_c = 1'b1;
        else mul_start_c = 1'b1;
      end
`endif
      OP_PUSH: begin
        if (at_full) err_c = 1'b1;
        else begin
          wa_en     = 1'b1;
          level_nxt = level + LW'(1);
          top_nxt   = input_data;
        end
      end
      OP_POP: begin
        if (!has1) err_c = 1'b1;
        else begin
          level_nxt = level - LW'(1);
          top_nxt   = has2 ? nxt_v : '0;
        end
      end
      default: err_c = 1'b1;
    endcase
    wa_we = wa_en && accept && rst;
    wb_we = wb_en && accept && rst;
`ifdef STACK_ALU_MUL_EN
    if (state == MUL_BUSY && mul_last) begin
      wb_we   = rst;
      wb_data = mul_acc_nxt[N-1:0];
    end
`endif
  end

  // Stack storage; contents are not reset, only level qualifies them
  always_ff @(posedge clk) begin
    if (wa_we) mem[wa_addr] <= wa_data;
    if (wb_we) mem[wb_addr] <= wb_data;
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      error       <= 1'b0;
      overflow    <= 1'b0;
      output_data <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
`ifdef STACK_ALU_MUL_EN
      mul_a       <= '0;
      mul_b       <= '0;
      mul_acc     <= '0;
      mul_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          error     <= 1'b0;
          overflow  <= 1'b0;
          if (accept) begin
            in_ready <= 1'b0;
            if (mul_start_c) begin
`ifdef STACK_ALU_MUL_EN
              state   <= MUL_BUSY;
              mul_a   <= {{N{1'b0}}, top_v};
              mul_b   <= nxt_v;
              mul_acc <= '0;
              mul_cnt <= '0;
`endif
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              error       <= err_c;
              overflow    <= ovf_c;
              level       <= level_nxt;
              output_data <= top_nxt;
              empty       <= (level_nxt == LW'(0));
              full        <= (level_nxt == LW'(STACK_SIZE));
            end
          end
        end
`ifdef STACK_ALU_MUL_EN
        MUL_BUSY: begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + CW'(1);
          if (mul_last) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            error       <= 1'b0;
            overflow    <= |mul_acc_nxt[2*N-1:N];
            output_data <= mul_acc_nxt[N-1:0];
            level       <= level - LW'(1);
            empty       <= 1'b0;
            full        <= 1'b0;
          end
        end
`endif
        DONE: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          error     <= 1'b0;
          overflow  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
